adder_op_sequencer: RTL and testbench



---
 rtl/adder_op_sequencer.sv | 127 ++++++++++++
 tb/tb_adder_op_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_op_sequencer.sv
// Handshaked wrapper around the CLA adder: registers one operand triple, waits a
// fixed settle budget, then holds the captured result until the consumer takes it.
module adder_op_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  input  logic             add_of,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_of,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       accept, capture, handshake;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Launch stage: operands stay parked on the adder inputs until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else if (accept) begin
      add_a   <= in_a;
      add_b   <= in_b;
      add_cin <= in_cin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      settle_cnt <= 4'd0;
    else if (accept)                                 settle_cnt <= SETTLE_LOAD;
    else if (state == SETTLE && settle_cnt != 4'd0)  settle_cnt <= settle_cnt - 4'd1;
  end

  // Capture stage: result fields persist after the handshake; only out_valid drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_of    <= 1'b0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_sum   <= add_sum;
      out_cout  <= add_cout;
      out_of    <= add_of;
      out_valid <= 1'b1;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (clear_stats) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (handshake) begin
      op_count <= sat_inc(op_count);
      if (out_of) ovf_count <= sat_inc(ovf_count);
    end
  end

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Bench for adder_op_sequencer: four instances (default, 2-bit counters,
// settle 1, settle 5), each wrapped around a behavioural 32-bit adder.
module tb_adder_op_sequencer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid [N];
  logic        in_ready [N];
  logic [31:0] in_a     [N];
  logic [31:0] in_b     [N];
  logic        in_cin   [N];
  logic [31:0] add_a    [N];
  logic [31:0] add_b    [N];
  logic        add_cin  [N];
  logic [31:0] add_sum  [N];
  logic        add_cout [N];
  logic        add_of   [N];
  logic        out_valid[N];
  logic        out_ready[N];
  logic [31:0] out_sum  [N];
  logic        out_cout [N];
  logic        out_of   [N];
  logic        clear_stats[N];
  logic [15:0] op_count [N];
  logic [15:0] ovf_count[N];

  int compared   = 0;
  int mismatched = 0;
  int exp_op [N];
  int exp_ovf[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int SC = (g == 2) ? 1 : (g == 3) ? 5 : 2;
    localparam int CW = (g == 1) ? 2 : 16;
    logic [CW-1:0] opc, ovc;

    assign {add_cout[g], add_sum[g]} = {1'b0, add_a[g]} + {1'b0, add_b[g]} + {32'd0, add_cin[g]};
    assign add_of[g] = (add_a[g][31] == add_b[g][31]) && (add_sum[g][31] != add_a[g][31]);
    assign op_count[g]  = 16'(opc);
    assign ovf_count[g] = 16'(ovc);

    adder_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a[g]), .in_b(in_b[g]), .in_cin(in_cin[g]),
      .add_a(add_a[g]), .add_b(add_b[g]), .add_cin(add_cin[g]),
      .add_sum(add_sum[g]), .add_cout(add_cout[g]), .add_of(add_of[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_sum(out_sum[g]), .out_cout(out_cout[g]), .out_of(out_of[g]),
      .clear_stats(clear_stats[g]),
      .op_count(opc), .ovf_count(ovc)
    );
  end

  function automatic int lat_of(input int idx);
    return (idx == 2) ? 1 : (idx == 3) ? 5 : 2;
  endfunction

  function automatic int cmax(input int idx);
    return (idx == 1) ? 3 : 65535;
  endfunction

  // One full operation on instance idx, checked against plain integer arithmetic.
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input int bp, input bit hold_valid,
                       input bit clr, input bit stop_in_done, input string tag);
    longint unsigned u;
    longint          s;
    logic [31:0]     e_sum;
    logic            e_cout, e_of;
    int              lat;
    u      = longint'(a) + longint'(b) + longint'(cin);
    s      = longint'(signed'(a)) + longint'(signed'(b)) + longint'(cin);
    e_sum  = u[31:0];
    e_cout = u[32];
    e_of   = (s > 64'sd2147483647) || (s < -64'sd2147483648);

    in_a[idx] = a; in_b[idx] = b; in_cin[idx] = cin; in_valid[idx] = 1'b1;
    compared++;
    if (in_ready[idx] !== 1'b1) begin
      mismatched++;
      $display("FAIL %s in_ready_idle: got %b want 1", tag, in_ready[idx]);
    end
    @(posedge clk); #1;
    if (!hold_valid) in_valid[idx] = 1'b0;
    compared++;
    if ({add_a[idx], add_b[idx], add_cin[idx]} !== {a, b, cin}) begin
      mismatched++;
      $display("FAIL %s launch: got %h %h %b want %h %h %b", tag,
               add_a[idx], add_b[idx], add_cin[idx], a, b, cin);
    end

    lat = 0;
    while (out_valid[idx] !== 1'b1 && lat <= 20) begin
      compared++;
      if (in_ready[idx] !== 1'b0 || {add_a[idx], add_b[idx], add_cin[idx]} !== {a, b, cin}) begin
        mismatched++;
        $display("FAIL %s settle_hold: in_ready %b add_a %h want in_ready 0 add_a %h",
                 tag, in_ready[idx], add_a[idx], a);
      end
      @(posedge clk); #1;
      lat++;
    end
    compared++;
    if (lat != lat_of(idx)) begin
      mismatched++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, lat_of(idx));
    end
    if (out_valid[idx] !== 1'b1) return;
    in_valid[idx] = 1'b0;

    compared++;
    if ({out_sum[idx], out_cout[idx], out_of[idx]} !== {e_sum, e_cout, e_of}) begin
      mismatched++;
      $display("FAIL %s result: got %h c%b o%b want %h c%b o%b", tag,
               out_sum[idx], out_cout[idx], out_of[idx], e_sum, e_cout, e_of);
    end

    for (int i = 0; i < bp; i++) begin
      out_ready[idx] = 1'b0;
      @(posedge clk); #1;
      compared++;
      if (out_valid[idx] !== 1'b1 || in_ready[idx] !== 1'b0 ||
          {out_sum[idx], out_cout[idx], out_of[idx]} !== {e_sum, e_cout, e_of} ||
          op_count[idx] !== 16'(exp_op[idx]) || ovf_count[idx] !== 16'(exp_ovf[idx])) begin
        mismatched++;
        $display("FAIL %s backpressure[%0d]: v%b r%b sum %h op %0d ovf %0d want v1 r0 sum %h op %0d ovf %0d",
                 tag, i, out_valid[idx], in_ready[idx], out_sum[idx], op_count[idx],
                 ovf_count[idx], e_sum, exp_op[idx], exp_ovf[idx]);
      end
    end
    if (stop_in_done) return;

    out_ready[idx] = 1'b1; clear_stats[idx] = clr;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0; clear_stats[idx] = 1'b0;
    if (clr) begin
      exp_op[idx] = 0; exp_ovf[idx] = 0;
    end else begin
      if (exp_op[idx] < cmax(idx)) exp_op[idx]++;
      if (e_of && exp_ovf[idx] < cmax(idx)) exp_ovf[idx]++;
    end
    compared++;
    if (out_valid[idx] !== 1'b0 || in_ready[idx] !== 1'b1 || out_sum[idx] !== e_sum ||
        add_a[idx] !== a) begin
      mismatched++;
      $display("FAIL %s handshake: v%b r%b sum %h add_a %h want v0 r1 sum %h add_a %h",
               tag, out_valid[idx], in_ready[idx], out_sum[idx], add_a[idx], e_sum, a);
    end
    compared++;
    if (op_count[idx] !== 16'(exp_op[idx]) || ovf_count[idx] !== 16'(exp_ovf[idx])) begin
      mismatched++;
      $display("FAIL %s counters: got op %0d ovf %0d want op %0d ovf %0d", tag,
               op_count[idx], ovf_count[idx], exp_op[idx], exp_ovf[idx]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    for (int i = 0; i < N; i++) begin
      compared++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || add_a[i] !== 32'd0 ||
          out_sum[i] !== 32'd0 || op_count[i] !== 16'd0 || ovf_count[i] !== 16'd0) begin
        mismatched++;
        $display("FAIL reset_state[%0d]: r%b v%b add_a %h sum %h op %0d ovf %0d want r1 v0 zeros",
                 i, in_ready[i], out_valid[i], add_a[i], out_sum[i], op_count[i], ovf_count[i]);
      end
      exp_op[i] = 0; exp_ovf[i] = 0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_op(0, 32'h7fffffff, 32'h7fffffff, 1'b0, 0, 1'b0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_neg_backpressure();
    do_op(0, 32'h8fffffff, 32'h8fffffff, 1'b0, 10, 1'b0, 1'b0, 1'b0, "neg_bp");
  endtask

  task automatic test_carry_in();
    do_op(0, 32'h000000af, 32'h000000af, 1'b1, 1, 1'b0, 1'b0, 1'b0, "carry_in");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int k = 0; k < 25; k++) begin
      a = $urandom;
      b = $urandom;
      if ((k % 5) == 0) a = 32'h80000000;
      if ((k % 7) == 0) b = 32'hffffffff;
      do_op(0, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'b0, "random");
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 5; k++)
      do_op(1, 32'h7fffffff, 32'h00000001 + 32'($urandom_range(0, 15)), 1'b0, 0,
            1'b0, 1'b0, 1'b0, "saturate");
    do_op(1, 32'h80000000, 32'h80000000, 1'b0, 0, 1'b0, 1'b1, 1'b0, "clear_on_hs");
    do_op(1, 32'h00000001, 32'h00000002, 1'b0, 0, 1'b0, 1'b0, 1'b0, "after_clear");
  endtask

  task automatic test_latency();
    do_op(2, 32'h00000000, 32'hffffffff, 1'b0, 1, 1'b1, 1'b0, 1'b0, "lat1");
    do_op(3, 32'h00000000, 32'hffffffff, 1'b0, 1, 1'b1, 1'b0, 1'b0, "lat5");
    do_op(2, $urandom, $urandom, 1'b1, 0, 1'b0, 1'b0, 1'b0, "lat1_rand");
    do_op(3, $urandom, $urandom, 1'b1, 2, 1'b0, 1'b0, 1'b0, "lat5_rand");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++)
      do_op(0, $urandom, $urandom, 1'b0, 0, 1'b1, 1'b0, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid_done();
    do_op(0, 32'h7fffffff, 32'h00000001, 1'b0, 2, 1'b0, 1'b0, 1'b1, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      exp_op[i] = 0; exp_ovf[i] = 0;
    end
    compared++;
    if (out_valid[0] !== 1'b0 || out_sum[0] !== 32'd0 || out_cout[0] !== 1'b0 ||
        out_of[0] !== 1'b0 || op_count[0] !== 16'd0 || ovf_count[0] !== 16'd0 ||
        in_ready[0] !== 1'b1 || add_a[0] !== 32'd0) begin
      mismatched++;
      $display("FAIL async_reset: v%b sum %h o%b op %0d ovf %0d r%b add_a %h want all zero r1",
               out_valid[0], out_sum[0], out_of[0], op_count[0], ovf_count[0],
               in_ready[0], add_a[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset_idle: r%b v%b want r1 v0", in_ready[0], out_valid[0]);
    end
    do_op(0, 32'h000000af, 32'h000000af, 1'b1, 0, 1'b0, 1'b0, 1'b0, "post_reset_op");
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0; in_cin[i] = 1'b0;
      out_ready[i] = 1'b0; clear_stats[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_neg_backpressure();
    test_carry_in();
    test_random();
    test_saturation();
    test_latency();
    test_back_to_back();
    test_reset_mid_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
